// File: rtl/cic_comb_mc_if.sv
// Sample stream into and out of the multi-channel CIC comb section.
interface cic_comb_mc_if #(
    parameter int IW  = 17,
    parameter int OW  = 17,
    parameter int CHW = 1
);
    logic                 nd;
    logic [CHW-1:0]       ch_in;
    logic signed [IW-1:0] xin;
    logic                 vout;
    logic [CHW-1:0]       ch_out;
    logic signed [OW-1:0] yout;
    logic                 err;

    // No ready signal: a sample transfers on every edge with nd high, and the
    // consumer must take yout/ch_out on every cycle vout is high.
    modport master (output nd, ch_in, xin, input vout, ch_out, yout, err);
    modport slave  (input nd, ch_in, xin, output vout, ch_out, yout, err);
endinterface

// File: rtl/cic_comb_mc.sv
// Pipelined N-stage (1 - z^-M) comb with time-multiplexed channels, followed by
// round-half-up and positive saturation from IW down to OW bits.
module cic_comb_mc #(
    parameter int IW = 17,
    parameter int OW = 17,
    parameter int N  = 3,
    parameter int M  = 1,
    parameter int CH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    cic_comb_mc_if.slave bus
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int S   = IW - OW;
    localparam logic [CHW:0] CH_LIM = (CHW + 1)'(CH);

    typedef logic signed [IW-1:0] samp_t;

    // Pipeline slot 0 is the input register, slot k holds the output of stage k.
    samp_t          x_q [0:N];
    logic           v_q [0:N];
    logic [CHW-1:0] c_q [0:N];
    samp_t          dl_q [0:N-1][0:CH-1][0:M-1];
    samp_t          x_d [1:N];

    logic                 vout_q;
    logic                 err_q;
    logic [CHW-1:0]       chout_q;
    logic signed [OW-1:0] yout_q;
    logic signed [OW-1:0] yout_d;
    logic                 in_ok;
    logic                 in_bad;

    assign in_ok  = bus.nd && ({1'b0, bus.ch_in} < CH_LIM);
    assign in_bad = bus.nd && ({1'b0, bus.ch_in} >= CH_LIM);

    // Each stage subtracts the sample seen M valid samples ago on the same channel.
    always_comb begin
        for (int k = 1; k <= N; k++) begin
            x_d[k] = x_q[k-1] - dl_q[k-1][c_q[k-1]][M-1];
        end
    end

    generate
        if (S > 0) begin : g_rnd
            localparam logic signed [IW:0] HALF = (IW + 1)'(1 << (S - 1));
            localparam logic signed [IW:0] YMAX = (IW + 1)'((1 << (OW - 1)) - 1);
            logic signed [IW:0] t_sum;
            logic signed [IW:0] t_sh;
            always_comb begin
                t_sum  = $signed({x_q[N][IW-1], x_q[N]}) + HALF;
                t_sh   = t_sum >>> S;
                yout_d = (t_sh > YMAX) ? YMAX[OW-1:0] : t_sh[OW-1:0];
            end
        end else begin : g_pass
            assign yout_d = x_q[N];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int k = 0; k <= N; k++) begin
                v_q[k] <= 1'b0;
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
            for (int k = 0; k < N; k++) begin
                for (int c = 0; c < CH; c++) begin
                    for (int m = 0; m < M; m++) begin
                        dl_q[k][c][m] <= '0;
                    end
                end
            end
            vout_q  <= 1'b0;
            err_q   <= 1'b0;
            chout_q <= '0;
            yout_q  <= '0;
        end else begin
            v_q[0] <= in_ok;
            err_q  <= in_bad;
            if (in_ok) begin
                x_q[0] <= bus.xin;
                c_q[0] <= bus.ch_in;
            end
            // Only the channel owning a valid sample advances its delay line.
            for (int k = 1; k <= N; k++) begin
                v_q[k] <= v_q[k-1];
                if (v_q[k-1]) begin
                    x_q[k] <= x_d[k];
                    c_q[k] <= c_q[k-1];
                    dl_q[k-1][c_q[k-1]][0] <= x_q[k-1];
                    for (int m = 1; m < M; m++) begin
                        dl_q[k-1][c_q[k-1]][m] <= dl_q[k-1][c_q[k-1]][m-1];
                    end
                end
            end
            vout_q <= v_q[N];
            if (v_q[N]) begin
                yout_q  <= yout_d;
                chout_q <= c_q[N];
            end
        end
    end

    assign bus.vout   = vout_q;
    assign bus.err    = err_q;
    assign bus.ch_out = chout_q;
    assign bus.yout   = yout_q;
endmodule

// File: tb/tb_cic_comb_mc.sv
// Bench for cic_comb_mc: four differently parameterised instances share one
// input bus; a binomial-expansion reference model scores every output cycle.
module tb_cic_comb_mc;
    localparam int IW = 17;
    localparam int ND = 4;
    localparam int N_P  [ND] = '{3, 1, 3, 1};
    localparam int M_P  [ND] = '{1, 1, 1, 2};
    localparam int CH_P [ND] = '{3, 1, 1, 1};
    localparam int OW_P [ND] = '{17, 17, 12, 17};

    typedef struct packed {
        int                 due;
        logic [1:0]         ch;
        logic [IW-1:0]      y;
    } exp_t;

    typedef struct packed {
        int cyc;
        int ch;
        int y;
    } cap_t;

    typedef struct {
        bit clr;
        bit nd;
        int dut;
        int ch;
        int x;
        int gap;
        bit chk;
        int exp_y;
        int exp_ch;
    } vec_t;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic              nd_d [ND];
    logic [1:0]        ch_d [ND];
    logic [IW-1:0]     xin;
    logic              vout_w [ND];
    logic [1:0]        chout_w [ND];
    logic [IW-1:0]     yout_w [ND];
    logic              err_w [ND];

    always #5 clk = ~clk;

    cic_comb_mc_if #(.IW(IW), .OW(17), .CHW(2)) if0 ();
    cic_comb_mc_if #(.IW(IW), .OW(17), .CHW(1)) if1 ();
    cic_comb_mc_if #(.IW(IW), .OW(12), .CHW(1)) if2 ();
    cic_comb_mc_if #(.IW(IW), .OW(17), .CHW(1)) if3 ();

    cic_comb_mc #(.IW(IW), .OW(OW_P[0]), .N(N_P[0]), .M(M_P[0]), .CH(CH_P[0]))
        dut0 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if0));
    cic_comb_mc #(.IW(IW), .OW(OW_P[1]), .N(N_P[1]), .M(M_P[1]), .CH(CH_P[1]))
        dut1 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if1));
    cic_comb_mc #(.IW(IW), .OW(OW_P[2]), .N(N_P[2]), .M(M_P[2]), .CH(CH_P[2]))
        dut2 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if2));
    cic_comb_mc #(.IW(IW), .OW(OW_P[3]), .N(N_P[3]), .M(M_P[3]), .CH(CH_P[3]))
        dut3 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if3));

    assign if0.nd = nd_d[0];  assign if0.ch_in = ch_d[0];     assign if0.xin = xin;
    assign if1.nd = nd_d[1];  assign if1.ch_in = ch_d[1][0];  assign if1.xin = xin;
    assign if2.nd = nd_d[2];  assign if2.ch_in = ch_d[2][0];  assign if2.xin = xin;
    assign if3.nd = nd_d[3];  assign if3.ch_in = ch_d[3][0];  assign if3.xin = xin;

    assign vout_w[0] = if0.vout;  assign chout_w[0] = if0.ch_out;
    assign vout_w[1] = if1.vout;  assign chout_w[1] = {1'b0, if1.ch_out};
    assign vout_w[2] = if2.vout;  assign chout_w[2] = {1'b0, if2.ch_out};
    assign vout_w[3] = if3.vout;  assign chout_w[3] = {1'b0, if3.ch_out};
    assign yout_w[0] = if0.yout;
    assign yout_w[1] = if1.yout;
    assign yout_w[2] = {{5{if2.yout[11]}}, if2.yout};
    assign yout_w[3] = if3.yout;
    assign err_w[0] = if0.err;  assign err_w[1] = if1.err;
    assign err_w[2] = if2.err;  assign err_w[3] = if3.err;

    // ---------------- scoreboard state ----------------
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   chk_en = 0;
    bit   cap_en = 0;
    exp_t exp_q [ND][$];
    cap_t cap_q [ND][$];
    int   hist [ND][4][8];
    int   err_due [ND];
    int   last_y [ND];
    int   last_ch [ND];
    vec_t tbl [$];
    int   in_cyc [$];

    function automatic int sx(input logic [IW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int binom(input int n, input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // (1 - z^-M)^N expanded: sum_j (-1)^j C(N,j) x[n - jM], wrapped to IW bits.
    function automatic int comb_ref(input int k, input int c, input int x);
        int acc;
        int d;
        int xv;
        acc = 0;
        for (int j = 0; j <= N_P[k]; j++) begin
            d  = j * M_P[k];
            xv = (d == 0) ? x : hist[k][c][d-1];
            acc += ((j % 2) ? -1 : 1) * binom(N_P[k], j) * xv;
        end
        return sx(acc[IW-1:0]);
    endfunction

    function automatic int round_ref(input int k, input int y);
        int s;
        int t;
        int ymax;
        s = IW - OW_P[k];
        if (s == 0) return y;
        t    = (y + (1 << (s - 1))) >>> s;
        ymax = (1 << (OW_P[k] - 1)) - 1;
        if (t > ymax) t = ymax;
        return t;
    endfunction

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s dut%0d cyc %0d: got %0d, want %0d", name, k, cyc, act, exp);
        end
    endtask

    // Reference model: consumes the inputs sampled at each rising edge.
    always @(posedge clk) begin
        exp_t e;
        int   c;
        cyc++;
        for (int k = 0; k < ND; k++) begin
            if (!rst_n || clr) begin
                exp_q[k].delete();
                err_due[k] = -1;
                last_y[k]  = 0;
                last_ch[k] = 0;
                for (int cc = 0; cc < 4; cc++)
                    for (int d = 0; d < 8; d++) hist[k][cc][d] = 0;
            end else if (nd_d[k]) begin
                c = int'(ch_d[k]);
                if (c >= CH_P[k]) begin
                    err_due[k] = cyc;
                end else begin
                    e.due = cyc + N_P[k] + 1;
                    e.ch  = ch_d[k];
                    e.y   = IW'(round_ref(k, comb_ref(k, c, sx(xin))));
                    exp_q[k].push_back(e);
                    for (int d = 7; d > 0; d--) hist[k][c][d] = hist[k][c][d-1];
                    hist[k][c][0] = sx(xin);
                end
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        bit   ev;
        cap_t cp;
        if (chk_en) begin
            for (int k = 0; k < ND; k++) begin
                ev = 0;
                if (exp_q[k].size() > 0 && exp_q[k][0].due == cyc) begin
                    e = exp_q[k].pop_front();
                    ev = 1;
                    last_y[k]  = sx(e.y);
                    last_ch[k] = int'(e.ch);
                end
                chk("vout", k, int'(vout_w[k]), int'(ev));
                chk("yout", k, sx(yout_w[k]), last_y[k]);
                chk("ch_out", k, int'(chout_w[k]), last_ch[k]);
                chk("err", k, int'(err_w[k]), int'(err_due[k] == cyc));
                if (cap_en && vout_w[k]) begin
                    cp.cyc = cyc;
                    cp.ch  = int'(chout_w[k]);
                    cp.y   = sx(yout_w[k]);
                    cap_q[k].push_back(cp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_all();
        clr = 1'b0;
        for (int k = 0; k < ND; k++) begin
            nd_d[k] = 1'b0;
            ch_d[k] = 2'd0;
        end
    endtask

    task automatic add(input bit c, input bit n, input int d, input int ch, input int x,
                       input int gap, input bit ck, input int ey, input int ech);
        vec_t v;
        v.clr = c;  v.nd = n;   v.dut = d;   v.ch = ch;    v.x = x;
        v.gap = gap; v.chk = ck; v.exp_y = ey; v.exp_ch = ech;
        tbl.push_back(v);
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < ND; k++) begin
            chk({tag, "_vout"}, k, int'(vout_w[k]), 0);
            chk({tag, "_yout"}, k, sx(yout_w[k]), 0);
            chk({tag, "_ch"},   k, int'(chout_w[k]), 0);
            chk({tag, "_err"},  k, int'(err_w[k]), 0);
        end
    endtask

    function automatic logic [IW-1:0] rand_x();
        case ($urandom_range(0, 4))
            0:       return IW'(65535);
            1:       return IW'(-65536);
            2:       return IW'(int'($urandom_range(0, 20)) - 10);
            default: return IW'($urandom);
        endcase
    endfunction

    // ---------------- test sequence ----------------
    cap_t cp;
    int   k;

    initial begin
        idle_all();
        xin = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        chk_en = 1;
        rst_n  = 1'b1;

        // clr, nd, dut, ch, x, gap, chk, exp_y, exp_ch
        add(0, 1, 0, 0, 1, 3, 1, 1, 0);        // impulse, one nd every 4 clocks
        add(0, 1, 0, 0, 0, 3, 1, -3, 0);
        add(0, 1, 0, 0, 0, 3, 1, 3, 0);
        add(0, 1, 0, 0, 0, 3, 1, -1, 0);
        add(0, 1, 0, 0, 0, 6, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 65535, 0, 1, 65535, 0); // modular wrap
        add(0, 1, 1, 0, -65536, 6, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 1, 1, 0);        // two channels interleaved
        add(0, 1, 0, 1, 7, 0, 1, 7, 1);
        add(0, 1, 0, 0, 0, 0, 1, -3, 0);
        add(0, 1, 0, 1, 7, 0, 1, -14, 1);
        add(0, 1, 0, 0, 0, 0, 1, 3, 0);
        add(0, 1, 0, 1, 7, 0, 1, 7, 1);
        add(0, 1, 0, 0, 0, 0, 1, -1, 0);
        add(0, 1, 0, 1, 7, 6, 1, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 2, 0, 48, 0, 1, 2, 0);       // rounding to 12 bits
        add(0, 1, 2, 0, 0, 0, 1, -4, 0);
        add(0, 1, 2, 0, 0, 0, 1, 5, 0);
        add(0, 1, 2, 0, 0, 6, 1, -1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 2, 0, 65535, 6, 1, 2047, 0); // saturation
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 3, 0, 1, 0, 1, 1, 0);        // differential delay of 2
        add(0, 1, 3, 0, 2, 0, 1, 2, 0);
        add(0, 1, 3, 0, 3, 0, 1, 2, 0);
        add(0, 1, 3, 0, 4, 6, 1, 2, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 0);        // in flight when clr hits
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 5, 0, 0, 0, 0);        // clr with simultaneous nd
        add(0, 1, 0, 0, 1, 0, 1, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, -3, 0);
        add(0, 1, 0, 0, 0, 0, 1, 3, 0);
        add(0, 1, 0, 0, 0, 6, 1, -1, 0);

        cap_en = 1;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            idle_all();
            clr = tbl[i].clr;
            nd_d[tbl[i].dut] = tbl[i].nd;
            ch_d[tbl[i].dut] = 2'(tbl[i].ch);
            xin = IW'(tbl[i].x);
            @(posedge clk);
            #1;
            in_cyc.push_back(cyc);
            repeat (tbl[i].gap) begin
                @(negedge clk);
                idle_all();
                @(posedge clk);
            end
        end
        @(negedge clk);
        idle_all();
        repeat (8) @(negedge clk);
        cap_en = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].chk) begin
                k = tbl[i].dut;
                if (cap_q[k].size() == 0) begin
                    chk("dir_missing", k, 0, 1);
                end else begin
                    cp = cap_q[k].pop_front();
                    chk("dir_y", k, cp.y, tbl[i].exp_y);
                    chk("dir_ch", k, cp.ch, tbl[i].exp_ch);
                    chk("dir_latency", k, cp.cyc - in_cyc[i], N_P[k] + 1);
                end
            end
        end
        for (int j = 0; j < ND; j++) begin
            chk("dir_extra", j, cap_q[j].size(), 0);
            cap_q[j].delete();
        end

        // Out-of-range channel on the 3-channel instance.
        @(negedge clk);
        idle_all();
        nd_d[0] = 1'b1;
        ch_d[0] = 2'd3;
        xin = IW'(9);
        @(negedge clk);
        idle_all();
        chk("err_pulse", 0, int'(err_w[0]), 1);
        @(negedge clk);
        chk("err_once", 0, int'(err_w[0]), 0);
        repeat (N_P[0] + 2) begin
            @(negedge clk);
            chk("err_no_vout", 0, int'(vout_w[0]), 0);
        end

        // Randomised traffic with occasional clear and reset.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            clr   = ($urandom_range(0, 79) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            xin   = rand_x();
            for (int j = 0; j < ND; j++) begin
                nd_d[j] = ($urandom_range(0, 3) != 0);
                if (j == 0) ch_d[j] = 2'($urandom_range(0, 3));
                else        ch_d[j] = ($urandom_range(0, 15) == 0) ? 2'd1 : 2'd0;
            end
        end
        @(negedge clk);
        idle_all();
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // One-cycle reset after traffic: everything reads zero right after it.
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("rst_pulse");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
